spypath_meas_ctrl: RTL

- Sequencer and arbiter for a bank of delay-chain paths under test.
- For the selected path it performs 2^LOG2_TRIALS launch/capture trials. Each trial settles the path low, launches a rising edge, and counts clock cycles until the path output changes.
- It reports the summed, minimum and maximum cycle counts.
- It sits between the host/UART control logic and the path bank. Only one path is exercised at a time; all other launch lines are held low.

---
 rtl/spypath_meas_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/spypath_meas_ctrl.sv
`timescale 1ns/1ps
// Launch/capture sequencer for a bank of delay-chain paths under test: runs
// 2^LOG2_TRIALS trials on one selected path and reports sum/min/max latency.

module spypath_meas_ctrl_chk #(
    parameter int NUM_PATHS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PATHS-1:0] path_launch,
    input  logic                 busy,
    input  logic                 done
);

    a_launch_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(path_launch));

    a_launch_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (|path_launch) |-> busy);

    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> !busy);

endmodule

module spypath_meas_ctrl #(
    parameter int NUM_PATHS   = 4,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = 12,
    parameter int LOG2_TRIALS = 4,
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT     = 4000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [SEL_W-1:0]             path_sel,
    output logic [NUM_PATHS-1:0]         path_launch,
    input  logic [NUM_PATHS-1:0]         path_result,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   err,
    output logic [CNT_W+LOG2_TRIALS-1:0] sum_cnt,
    output logic [CNT_W-1:0]             min_cnt,
    output logic [CNT_W-1:0]             max_cnt
);

    localparam int SUM_W = CNT_W + LOG2_TRIALS;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0]       SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]       TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [LOG2_TRIALS-1:0] LAST_TRIAL  = {LOG2_TRIALS{1'b1}};
    localparam logic [SEL_W:0]         PATH_LIMIT  = (SEL_W + 1)'(NUM_PATHS);
    localparam logic [1:0]             ERR_OK      = 2'd0;
    localparam logic [1:0]             ERR_TIMEOUT = 2'd1;
    localparam logic [1:0]             ERR_BAD_SEL = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_COUNT  = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                 state_r;
    logic [NUM_PATHS-1:0]   s1_r;
    logic [NUM_PATHS-1:0]   s2_r;
    logic [NUM_PATHS-1:0]   launch_r;
    logic [NUM_PATHS-1:0]   sel_dec_s;
    logic [SEL_W-1:0]       sel_r;
    logic [SET_W-1:0]       settle_cnt_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       meas_r;
    logic [CNT_W-1:0]       min_r;
    logic [CNT_W-1:0]       max_r;
    logic [SUM_W-1:0]       sum_r;
    logic [LOG2_TRIALS-1:0] trial_r;
    logic                   baseline_r;
    logic                   busy_r;
    logic                   done_r;
    logic [1:0]             err_r;
    logic                   sel_bit_s;
    logic                   sel_ok_s;
    logic                   changed_s;

    // Decode the latched select and pick out its synchronized result bit.
    always_comb begin
        sel_dec_s = {NUM_PATHS{1'b0}};
        for (int i = 0; i < NUM_PATHS; i++) begin
            sel_dec_s[i] = (sel_r == SEL_W'(i));
        end
        sel_bit_s = |(s2_r & sel_dec_s);
        sel_ok_s  = ({1'b0, path_sel} < PATH_LIMIT);
        // Polarity-agnostic: any departure from the settled level counts.
        changed_s = sel_bit_s ^ baseline_r;
    end

    // Two-flop synchronizer on every raw path output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= {NUM_PATHS{1'b0}};
            s2_r <= {NUM_PATHS{1'b0}};
        end else begin
            s1_r <= path_result;
            s2_r <= s1_r;
        end
    end

    // Measurement sequencer with registered launch lines and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= {SEL_W{1'b0}};
            settle_cnt_r <= {SET_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            meas_r       <= {CNT_W{1'b0}};
            min_r        <= {CNT_W{1'b0}};
            max_r        <= {CNT_W{1'b0}};
            sum_r        <= {SUM_W{1'b0}};
            trial_r      <= {LOG2_TRIALS{1'b0}};
            baseline_r   <= 1'b0;
            launch_r     <= {NUM_PATHS{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= ERR_OK;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    launch_r <= {NUM_PATHS{1'b0}};
                    if (start) begin
                        if (sel_ok_s) begin
                            sel_r        <= path_sel;
                            sum_r        <= {SUM_W{1'b0}};
                            min_r        <= {CNT_W{1'b1}};
                            max_r        <= {CNT_W{1'b0}};
                            trial_r      <= {LOG2_TRIALS{1'b0}};
                            settle_cnt_r <= {SET_W{1'b0}};
                            busy_r       <= 1'b1;
                            state_r      <= ST_SETTLE;
                        end else begin
                            // Rejected select: report and leave results untouched.
                            done_r  <= 1'b1;
                            err_r   <= ERR_BAD_SEL;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    launch_r <= {NUM_PATHS{1'b0}};
                    if (settle_cnt_r == SETTLE_LAST) begin
                        baseline_r <= sel_bit_s;
                        cnt_r      <= {CNT_W{1'b0}};
                        launch_r   <= sel_dec_s;
                        state_r    <= ST_COUNT;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SET_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (changed_s) begin
                        meas_r   <= cnt_r;
                        launch_r <= {NUM_PATHS{1'b0}};
                        state_r  <= ST_ACCUM;
                    end else if (cnt_r == TIMEOUT_CNT) begin
                        launch_r <= {NUM_PATHS{1'b0}};
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        err_r    <= ERR_TIMEOUT;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_ACCUM: begin
                    launch_r <= {NUM_PATHS{1'b0}};
                    sum_r    <= sum_r + {{LOG2_TRIALS{1'b0}}, meas_r};
                    if (meas_r < min_r) begin
                        min_r <= meas_r;
                    end
                    if (meas_r > max_r) begin
                        max_r <= meas_r;
                    end
                    if (trial_r == LAST_TRIAL) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        err_r   <= ERR_OK;
                        state_r <= ST_DONE;
                    end else begin
                        trial_r      <= trial_r + LOG2_TRIALS'(1);
                        settle_cnt_r <= {SET_W{1'b0}};
                        state_r      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    launch_r <= {NUM_PATHS{1'b0}};
                    state_r  <= ST_IDLE;
                end
                default: begin
                    launch_r <= {NUM_PATHS{1'b0}};
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign path_launch = launch_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign sum_cnt     = sum_r;
    assign min_cnt     = min_r;
    assign max_cnt     = max_r;

    spypath_meas_ctrl_chk #(
        .NUM_PATHS(NUM_PATHS)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .path_launch(launch_r),
        .busy       (busy_r),
        .done       (done_r)
    );

endmodule
